ram_clear_seq: RTL
==================

RAM_CLEAR_SEQ -- requirements
Module: ram_clear_seq

Interface
REQ-001 SHALL have parameter SDR_LAST, default 25'h1FFFFFF: last SDRAM word address cleared.
REQ-002 SHALL have parameter DDR_LAST, default 29'h0FFFFFFF: last DDR3 64-bit word address cleared.
REQ-003 SHALL have parameter GAP, default 9: idle cycles inserted before every write request (range 0..255).
REQ-004 SHALL have parameter AUTO, default 1: 1 = begin clearing on reset release without a start pulse.
REQ-005 clk_sys  in  1  system clock; all logic on rising edge.
REQ-006 RESET  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  single-cycle pulse; (re)starts both channels from address 0.
REQ-008 sdr_ready  in  1  SDRAM controller idle / previous request accepted.
REQ-009 ddr_busy  in  1  DDR3 Avalon waitrequest.
REQ-010 sdr_addr  out  25  SDRAM write address.
REQ-011 sdr_we  out  1  SDRAM write request.
REQ-012 ddr_addr  out  29  DDR3 word address.
REQ-013 ddr_we  out  1  DDR3 write request.
REQ-014 ddr_be  out  8  byte enables; constant 8'hFF.
REQ-015 ddr_burstcnt  out  8  burst length; constant 8'd1.
REQ-016 done  out  1  both channels finished.
REQ-017 progress  out  8  ddr_addr[28:21] of DDR channel; 8'hFF when its channel is DONE.

Function
REQ-018 Each channel SHALL be an FSM with states IDLE, GAP, ISSUE, DONE.
REQ-019 IDLE -> GAP on start, or on the first cycle after reset release when AUTO=1; address loads 0, gap counter loads GAP.
REQ-020 GAP SHALL decrement its counter each cycle and go to ISSUE the cycle after it reads 0; GAP=0 gives exactly one GAP cycle.
REQ-021 ISSUE SHALL assert we and hold address stable until accepted.
REQ-022 Acceptance SHALL be we=1 and busy=0 at the same rising edge, with busy = ddr_busy for DDR and busy = ~sdr_ready for SDRAM.
REQ-023 On acceptance, if address == LAST the channel SHALL go to DONE; otherwise address increments by 1 and the channel returns to GAP with counter reloaded.
REQ-024 we SHALL deassert in the cycle following acceptance, giving exactly one accepted request per address.
REQ-025 Address SHALL never wrap; no request is issued past LAST.
REQ-026 DONE SHALL hold until start or reset; done = both channels in DONE, registered, asserting 1 cycle after the later channel enters DONE.
REQ-027 start in any state SHALL force the channel to GAP with address 0 and we=0 the next cycle, including when start coincides with acceptance.
REQ-028 Write data is implicitly zero and SHALL be driven externally; this block carries no data path.
REQ-029 The two channels SHALL run independently; neither channel's stall affects the other.

Reset
REQ-030 While RESET=0, sampled on a clk_sys edge: both channels IDLE, sdr_addr=0, ddr_addr=0, sdr_we=0, ddr_we=0, done=0, progress=0, gap counters=GAP.
REQ-031 Reset asserted mid-transfer SHALL drop we on the next edge regardless of busy; abandoned requests are not completed.
REQ-032 ddr_be and ddr_burstcnt SHALL be constants that are unaffected by reset.

Structure
REQ-033 Package ram_clear_pkg SHALL hold the channel state enum and default SDR_LAST/DDR_LAST constants.
REQ-034 Sub-module clr_channel (parameters AW, LAST, GAP) SHALL implement REQ-018..027 and be instantiated twice.
REQ-035 The top level SHALL contain only busy mapping, done/progress registers and constant outputs.

Verification
REQ-036 AUTO=1, SDR_LAST=3, DDR_LAST=3, GAP=2, no stall -> each channel issues addresses 0,1,2,3 one write every 4 cycles; done=1 after the last write; no further writes.
REQ-037 ddr_busy held 1 for 5 cycles during ISSUE at addr 1 -> ddr_we and ddr_addr=1 stable for those 5 cycles; accepted exactly once; SDRAM channel unaffected.
REQ-038 start pulsed while ddr_addr=2, coincident with acceptance -> next cycle ddr_we=0, ddr_addr=0; sequence restarts; done=0.
REQ-039 RESET=0 asserted while ddr_we=1 and ddr_busy=1 -> next edge ddr_we=0, ddr_addr=0, done=0; after release with AUTO=0 no writes occur until start.
REQ-040 GAP=0, DDR_LAST=1, sdr_ready=0 forever -> DDR channel reaches DONE; SDRAM channel stalls in ISSUE at addr 0; done stays 0; progress=8'hFF.

Source files
------------

// File: rtl/ram_clear_seq_pkg.sv
// Shared types and default end addresses for the SDRAM/DDR3 clear sequencer.
package ram_clear_pkg;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_GAP   = 2'd1,
        CH_ISSUE = 2'd2,
        CH_DONE  = 2'd3
    } ch_state_e;

    localparam logic [24:0] SDR_LAST_DEF = 25'h1FFFFFF;
    localparam logic [28:0] DDR_LAST_DEF = 29'h0FFFFFFF;
    localparam int unsigned GAP_W        = 8;

endpackage

// File: rtl/ram_clear_seq_channel.sv
// One clearing channel: walks addresses 0..LAST, one accepted write per address,
// with GAP+1 idle cycles before every request.
module clr_channel
    import ram_clear_pkg::*;
#(
    parameter int unsigned    AW   = 25,
    parameter logic [AW-1:0]  LAST = '1,
    parameter int unsigned    GAP  = 9
) (
    input  logic          clk_sys,
    input  logic          RESET,
    input  logic          go_i,
    input  logic          busy_i,
    output logic [AW-1:0] addr_o,
    output logic          we_o,
    output logic          done_o
);

    localparam logic [GAP_W-1:0] GAP_LD = GAP_W'(GAP);

    ch_state_e        state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [GAP_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        // A (re)start overrides everything, even an acceptance on this edge.
        if (go_i) begin
            state_d = CH_GAP;
            addr_d  = '0;
            cnt_d   = GAP_LD;
        end else begin
            case (state_q)
                CH_GAP: begin
                    if (cnt_q == '0) begin
                        state_d = CH_ISSUE;
                    end else begin
                        cnt_d = cnt_q - GAP_W'(1);
                    end
                end
                CH_ISSUE: begin
                    if (!busy_i) begin
                        if (addr_q == LAST) begin
                            state_d = CH_DONE;
                        end else begin
                            state_d = CH_GAP;
                            addr_d  = addr_q + AW'(1);
                            cnt_d   = GAP_LD;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!RESET) begin
            state_q <= CH_IDLE;
            addr_q  <= '0;
            cnt_q   <= GAP_LD;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign addr_o = addr_q;
    assign we_o   = (state_q == CH_ISSUE);
    assign done_o = (state_q == CH_DONE);

endmodule

// File: rtl/ram_clear_seq.sv
// Clears an SDRAM and a DDR3 memory in parallel with two independent channels;
// reports combined completion and coarse DDR progress.
module ram_clear_seq
    import ram_clear_pkg::*;
#(
    parameter logic [24:0] SDR_LAST = SDR_LAST_DEF,
    parameter logic [28:0] DDR_LAST = DDR_LAST_DEF,
    parameter int unsigned GAP      = 9,
    parameter bit          AUTO     = 1'b1
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        start,
    input  logic        sdr_ready,
    input  logic        ddr_busy,
    output logic [24:0] sdr_addr,
    output logic        sdr_we,
    output logic [28:0] ddr_addr,
    output logic        ddr_we,
    output logic [7:0]  ddr_be,
    output logic [7:0]  ddr_burstcnt,
    output logic        done,
    output logic [7:0]  progress
);

    logic       kick_q;
    logic       go;
    logic       sdr_done, ddr_done;
    logic       done_q;
    logic [7:0] progress_q;

    // kick_q is high only in the first cycle after reset release.
    always_ff @(posedge clk_sys) begin
        kick_q <= !RESET;
    end

    assign go = start || (AUTO && kick_q);

    clr_channel #(.AW(25), .LAST(SDR_LAST), .GAP(GAP)) u_sdr (
        .clk_sys (clk_sys),
        .RESET   (RESET),
        .go_i    (go),
        .busy_i  (!sdr_ready),
        .addr_o  (sdr_addr),
        .we_o    (sdr_we),
        .done_o  (sdr_done)
    );

    clr_channel #(.AW(29), .LAST(DDR_LAST), .GAP(GAP)) u_ddr (
        .clk_sys (clk_sys),
        .RESET   (RESET),
        .go_i    (go),
        .busy_i  (ddr_busy),
        .addr_o  (ddr_addr),
        .we_o    (ddr_we),
        .done_o  (ddr_done)
    );

    always_ff @(posedge clk_sys) begin
        if (!RESET) begin
            done_q     <= 1'b0;
            progress_q <= 8'h00;
        end else begin
            done_q     <= sdr_done && ddr_done && !start;
            progress_q <= ddr_done ? 8'hFF : ddr_addr[28:21];
        end
    end

    assign done         = done_q;
    assign progress     = progress_q;
    assign ddr_be       = 8'hFF;
    assign ddr_burstcnt = 8'd1;

endmodule
